riscv_dift_exc_ctrl: RTL

- Exception/interrupt request controller sitting directly upstream of the CSR block.
- Collects level interrupts and DIFT tag-check violations, prioritises them and raises one registered exception request to the core controller.
- After the controller acknowledges, pulses save_exc_cause_o with a stable cause for the CSR block to latch into mcause.
- Consumes the CSR block's irq enable and tag-check-register (TCR) outputs. Blocks further requests until the handler returns (exc_restore_i).

---
 rtl/riscv_defines.sv | 35 +++
 rtl/riscv_prio_enc.sv | 29 ++
 rtl/riscv_dift_exc_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Package     : riscv_defines
// Description : Shared constants for the DIFT exception controller: DIFT cause
//               codes, tag-check-register enable bit positions, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_defines;

  // Cause code of DIFT check class 0; class k reports base + k.
  localparam logic [4:0] DIFT_CAUSE_BASE_DEF = 5'h18;

  localparam logic [4:0] EXC_CAUSE_DIFT_JUMP   = DIFT_CAUSE_BASE_DEF + 5'd0;
  localparam logic [4:0] EXC_CAUSE_DIFT_BRANCH = DIFT_CAUSE_BASE_DEF + 5'd1;
  localparam logic [4:0] EXC_CAUSE_DIFT_LOAD   = DIFT_CAUSE_BASE_DEF + 5'd2;
  localparam logic [4:0] EXC_CAUSE_DIFT_STORE  = DIFT_CAUSE_BASE_DEF + 5'd3;
  localparam logic [4:0] EXC_CAUSE_DIFT_EXEC   = DIFT_CAUSE_BASE_DEF + 5'd4;

  // TCR bit 27+k enables DIFT check class k.
  localparam int TCR_CHK_EN_LSB    = 27;
  localparam int TCR_CHK_EN_JUMP   = TCR_CHK_EN_LSB + 0;
  localparam int TCR_CHK_EN_BRANCH = TCR_CHK_EN_LSB + 1;
  localparam int TCR_CHK_EN_LOAD   = TCR_CHK_EN_LSB + 2;
  localparam int TCR_CHK_EN_STORE  = TCR_CHK_EN_LSB + 3;
  localparam int TCR_CHK_EN_EXEC   = TCR_CHK_EN_LSB + 4;

  typedef enum logic [1:0] {
    EXC_IDLE     = 2'd0,
    EXC_REQ      = 2'd1,
    EXC_ACKD     = 2'd2,
    EXC_WAIT_RET = 2'd3
  } exc_state_t;

endpackage
`default_nettype wire

// File: rtl/riscv_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : riscv_prio_enc
// Description : Lowest-index-first priority encoder with valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_prio_enc #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_dift_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_dift_exc_ctrl
// Description : Collects level interrupts and DIFT tag-check violations,
//               raises one prioritised registered exception request and
//               strobes the cause into the CSR block after acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_dift_exc_ctrl
  import riscv_defines::*;
#(
  parameter int         N_IRQ           = 32,
  parameter int         N_DIFT_CHK      = 5,
  parameter logic [4:0] DIFT_CAUSE_BASE = 5'h18,
  parameter int         CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IRQ-1:0]      irq_i,
  input  logic                  irq_enable_i,
  input  logic [31:0]           tcr_i,
  input  logic [N_DIFT_CHK-1:0] dift_viol_i,
  input  logic                  exc_ack_i,
  input  logic                  exc_restore_i,
  output logic                  exc_req_o,
  output logic [5:0]            exc_cause_o,
  output logic                  save_exc_cause_o,
  output logic                  busy_o,
  output logic [N_DIFT_CHK-1:0] dift_pending_o,
  output logic [CNT_WIDTH-1:0]  viol_cnt_o,
  input  logic                  viol_cnt_clr_i
);

  localparam int c_DIFT_IDX_W = 3;
  localparam int c_IRQ_IDX_W  = 5;

  exc_state_t            state_q, state_d;
  logic [5:0]            cause_q, cause_d;
  logic                  is_irq_q, is_irq_d;
  logic [4:0]            sel_idx_q, sel_idx_d;
  logic [N_DIFT_CHK-1:0] pend_q, pend_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [N_DIFT_CHK-1:0]   w_acc;
  logic [N_DIFT_CHK-1:0]   w_dift_cand;
  logic [N_DIFT_CHK-1:0]   w_clr_mask;
  logic                    w_dift_vld;
  logic [c_DIFT_IDX_W-1:0] w_dift_idx;
  logic [N_IRQ-1:0]        w_irq_cand;
  logic                    w_irq_vld;
  logic [c_IRQ_IDX_W-1:0]  w_irq_idx;
  logic [31:0]             w_irq_ext;
  logic [CNT_WIDTH:0]      w_pop;
  logic [CNT_WIDTH:0]      w_sum;
  logic                    w_unused_tcr;

  // Only the check-enable field of the TCR matters here.
  assign w_unused_tcr = ^tcr_i;

  assign w_acc       = dift_viol_i & tcr_i[TCR_CHK_EN_LSB +: N_DIFT_CHK];
  assign w_dift_cand = pend_q | w_acc;
  assign w_irq_cand  = irq_enable_i ? irq_i : '0;
  assign w_irq_ext   = 32'(irq_i);

  riscv_prio_enc #(
    .WIDTH (N_DIFT_CHK),
    .IDX_W (c_DIFT_IDX_W)
  ) u_dift_enc (
    .req_i   (w_dift_cand),
    .valid_o (w_dift_vld),
    .idx_o   (w_dift_idx)
  );

  riscv_prio_enc #(
    .WIDTH (N_IRQ),
    .IDX_W (c_IRQ_IDX_W)
  ) u_irq_enc (
    .req_i   (w_irq_cand),
    .valid_o (w_irq_vld),
    .idx_o   (w_irq_idx)
  );

  // Number of violations accepted this cycle.
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < N_DIFT_CHK; k++) begin
      w_pop = w_pop + (CNT_WIDTH + 1)'(w_acc[k]);
    end
  end

  // Saturating violation counter; a clear still counts this cycle's events.
  always_comb begin
    w_sum = viol_cnt_clr_i ? w_pop : ({1'b0, cnt_q} + w_pop);
    cnt_d = w_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
  end

  // Request FSM: latch a frozen cause, wait for ack, strobe, wait for return.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    is_irq_d   = is_irq_q;
    sel_idx_d  = sel_idx_q;
    w_clr_mask = '0;
    case (state_q)
      EXC_IDLE: begin
        if (w_dift_vld) begin
          state_d   = EXC_REQ;
          is_irq_d  = 1'b0;
          sel_idx_d = 5'(w_dift_idx);
          cause_d   = {1'b0, DIFT_CAUSE_BASE + 5'(w_dift_idx)};
        end else if (w_irq_vld) begin
          state_d   = EXC_REQ;
          is_irq_d  = 1'b1;
          sel_idx_d = w_irq_idx;
          cause_d   = {1'b1, w_irq_idx};
        end
      end
      EXC_REQ: begin
        if (exc_ack_i) begin
          state_d = EXC_ACKD;
        end else if (is_irq_q && (!irq_enable_i || !w_irq_ext[sel_idx_q])) begin
          state_d = EXC_IDLE;
        end
      end
      EXC_ACKD: begin
        state_d = EXC_WAIT_RET;
        if (!is_irq_q) begin
          for (int k = 0; k < N_DIFT_CHK; k++) begin
            w_clr_mask[k] = (sel_idx_q == 5'(k));
          end
        end
      end
      EXC_WAIT_RET: begin
        if (exc_restore_i) begin
          state_d = EXC_IDLE;
        end
      end
      default: state_d = EXC_IDLE;
    endcase
    // A new event on a bit being cleared keeps that bit pending.
    pend_d = (pend_q & ~w_clr_mask) | w_acc;
  end

  // State, cause, pending and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EXC_IDLE;
      cause_q   <= '0;
      is_irq_q  <= 1'b0;
      sel_idx_q <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      is_irq_q  <= is_irq_d;
      sel_idx_q <= sel_idx_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign exc_req_o        = (state_q == EXC_REQ);
  assign save_exc_cause_o = (state_q == EXC_ACKD);
  assign busy_o           = (state_q != EXC_IDLE);
  assign exc_cause_o      = cause_q;
  assign dift_pending_o   = pend_q;
  assign viol_cnt_o       = cnt_q;

endmodule
`default_nettype wire
